// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: FSM states,
// nibble width and counter sizing helper.
package bin2bcd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int NIB_W = 4;

    // Counter only has to hold BIN_W-1, so clog2(BIN_W) bits suffice (min 1).
    function automatic int cnt_width(input int bin_w);
        return (bin_w <= 2) ? 1 : $clog2(bin_w);
    endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// One double-dabble correction cell: a BCD nibble of 5 or more gets +3 before
// the shift, so that doubling carries correctly into the next decimal digit.
module bcd_add3
    import bin2bcd_seq_pkg::*;
(
    input  logic [NIB_W-1:0] nib_i,
    output logic [NIB_W-1:0] nib_o
);

    assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/done handshake
// and overflow flag. Define BIN2BCD_SIGN_EN for two's-complement input and a sign output.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin,
    output logic                      ready,
    output logic                      busy,
    output logic                      done,
    output logic [NIB_W*DIGITS-1:0]   bcd,
    output logic                      ovf
`ifdef BIN2BCD_SIGN_EN
   ,output logic                      sign
`endif
);

    localparam int BCD_W = NIB_W * DIGITS;
    localparam int SR_W  = BIN_W + BCD_W;
    localparam int CNT_W = cnt_width(BIN_W);

    if ((BIN_W < 2) || (BIN_W > 32) || (DIGITS < 1) || (DIGITS > 10)) begin : g_bad_params
        $error("bin2bcd_seq: BIN_W must be 2..32 and DIGITS 1..10");
    end

    state_t             state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               acc_q, acc_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic [SR_W-1:0]    corr;
    logic [SR_W-1:0]    shifted;
    logic               out_bit;
    logic [BIN_W-1:0]   mag;
`ifdef BIN2BCD_SIGN_EN
    logic               sign_cap_q, sign_cap_d;
    logic               sign_q, sign_d;

    assign mag  = bin[BIN_W-1] ? (~bin + BIN_W'(1)) : bin;
    assign sign = sign_q;
`else
    assign mag  = bin;
`endif

    // Correct every BCD digit in parallel; the binary tail passes through untouched.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        bcd_add3 u_add3 (
            .nib_i (sr_q[BIN_W + NIB_W*gi +: NIB_W]),
            .nib_o (corr[BIN_W + NIB_W*gi +: NIB_W])
        );
    end
    assign corr[BIN_W-1:0] = sr_q[BIN_W-1:0];

    assign shifted = {corr[SR_W-2:0], 1'b0};
    assign out_bit = corr[SR_W-1];

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
`ifdef BIN2BCD_SIGN_EN
        sign_cap_d = sign_cap_q;
        sign_d     = sign_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d           = ST_SHIFT;
                    sr_d              = '0;
                    sr_d[BIN_W-1:0]   = mag;
                    cnt_d             = CNT_W'(BIN_W - 1);
                    acc_d             = 1'b0;
`ifdef BIN2BCD_SIGN_EN
                    sign_cap_d        = bin[BIN_W-1];
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                sr_d  = shifted;
                acc_d = acc_q | out_bit;
                if (cnt_q == '0) begin
                    // Results are published only here, so outputs never show a partial value.
                    state_d = ST_DONE;
                    bcd_d   = shifted[SR_W-1 -: BCD_W];
                    ovf_d   = acc_q | out_bit;
`ifdef BIN2BCD_SIGN_EN
                    sign_d  = sign_cap_q;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef BIN2BCD_SIGN_EN
            sign_cap_q <= 1'b0;
            sign_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
`ifdef BIN2BCD_SIGN_EN
            sign_cap_q <= sign_cap_d;
            sign_q     <= sign_d;
`endif
        end
    end

    assign busy  = (state_q == ST_SHIFT);
    assign ready = ~busy;
    assign done  = (state_q == ST_DONE);
    assign bcd   = bcd_q;
    assign ovf   = ovf_q;

endmodule
